// File: rtl/pigro_pkg.sv
// Shared PIGRO definitions: opcode values and instruction field positions.
package pigro_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPC_W    = 5;
    localparam int unsigned OPC_LSB  = 27;
    localparam int unsigned IMMF_BIT = 26;
    localparam int unsigned RD_LSB   = 22;
    localparam int unsigned RA_LSB   = 18;
    localparam int unsigned RB_LSB   = 14;
    localparam int unsigned RSLOT_W  = 4;

    localparam logic [OPC_W-1:0] NOP = 5'd0;
    localparam logic [OPC_W-1:0] JMP = 5'd1;
    localparam logic [OPC_W-1:0] ADD = 5'd2;
    localparam logic [OPC_W-1:0] SUB = 5'd3;
    localparam logic [OPC_W-1:0] STR = 5'd4;
    localparam logic [OPC_W-1:0] LDR = 5'd5;
    localparam logic [OPC_W-1:0] AND = 5'd6;
    localparam logic [OPC_W-1:0] OR  = 5'd7;

    // NOP and JMP are the only opcodes that read no register.
    function automatic logic reads_regs(input logic [OPC_W-1:0] opc);
        return (opc != NOP) && (opc != JMP);
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// RAW hazard detection: compares the used source registers against every
// downstream destination slot that is actually going to be written.
module hazard_cmp #(
    parameter int unsigned NSRC = 3,
    parameter int unsigned RA_W = 4
) (
    input  logic [RA_W-1:0]      src_a,
    input  logic [RA_W-1:0]      src_b,
    input  logic                 use_a,
    input  logic                 use_b,
    input  logic [NSRC*RA_W-1:0] hz_dst,
    input  logic [NSRC-1:0]      hz_wen,
    output logic                 hazard
);

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (hz_wen[i]) begin
                if (use_a && (hz_dst[i*RA_W +: RA_W] == src_a)) hazard = 1'b1;
                if (use_b && (hz_dst[i*RA_W +: RA_W] == src_b)) hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_stage.sv
// PIGRO decode/issue stage: field split, regfile addressing, RAW hazard stall,
// local jump resolution and a valid/ready output register.
module decode_stage
    import pigro_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 4,
    parameter int unsigned PC_W   = 5,
    parameter int unsigned IMM_W  = 18,
    parameter int unsigned NSRC   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   in_instr,
    input  logic [PC_W-1:0]      in_pc,
    output logic [RA_W-1:0]      rf_addr_a,
    output logic [RA_W-1:0]      rf_addr_b,
    input  logic [DATA_W-1:0]    rf_data_a,
    input  logic [DATA_W-1:0]    rf_data_b,
    input  logic [NSRC*RA_W-1:0] hz_dst,
    input  logic [NSRC-1:0]      hz_wen,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OPC_W-1:0]     out_opcode,
    output logic [RA_W-1:0]      out_dest,
    output logic [RA_W-1:0]      out_src_a,
    output logic [DATA_W-1:0]    out_data_a,
    output logic [DATA_W-1:0]    out_data_b,
    output logic [DATA_W-1:0]    out_imm,
    output logic                 out_isimm,
    output logic [PC_W-1:0]      out_pc,
    output logic                 jump_valid,
    output logic [PC_W-1:0]      jump_target,
    output logic                 stall,
    output logic [15:0]          stall_cnt
);

    logic [OPC_W-1:0]   opc;
    logic               isimm;
    logic [RSLOT_W-1:0] rd_slot, ra_slot, rb_slot;
    logic [RA_W-1:0]    rd, ra, rb;
    logic [IMM_W-1:0]   imm_field;
    logic [PC_W-1:0]    displ;
    logic               use_a, use_b, is_jmp, hazard, accept;
    logic [DATA_W-1:0]  imm_ext;
    logic [PC_W-1:0]    jump_target_d;

    logic               out_valid_q, out_isimm_q, jump_valid_q;
    logic [OPC_W-1:0]   out_opcode_q;
    logic [RA_W-1:0]    out_dest_q, out_src_a_q;
    logic [DATA_W-1:0]  out_data_a_q, out_data_b_q, out_imm_q;
    logic [PC_W-1:0]    out_pc_q, jump_target_q;
    logic [15:0]        stall_cnt_q;

    assign opc       = in_instr[OPC_LSB +: OPC_W];
    assign isimm     = in_instr[IMMF_BIT];
    assign rd_slot   = in_instr[RD_LSB +: RSLOT_W];
    assign ra_slot   = in_instr[RA_LSB +: RSLOT_W];
    assign rb_slot   = in_instr[RB_LSB +: RSLOT_W];
    assign rd        = rd_slot[RA_W-1:0];
    assign ra        = ra_slot[RA_W-1:0];
    assign rb        = rb_slot[RA_W-1:0];
    assign imm_field = in_instr[IMM_W-1:0];
    assign displ     = in_instr[PC_W-1:0];

    assign is_jmp = (opc == JMP);
    assign use_a  = reads_regs(opc);
    assign use_b  = use_a && !isimm;

    assign rf_addr_a = ra;
    assign rf_addr_b = rb;

    hazard_cmp #(
        .NSRC (NSRC),
        .RA_W (RA_W)
    ) u_hazard_cmp (
        .src_a  (ra),
        .src_b  (rb),
        .use_a  (use_a),
        .use_b  (use_b),
        .hz_dst (hz_dst),
        .hz_wen (hz_wen),
        .hazard (hazard)
    );

    assign stall    = in_valid && hazard;
    assign in_ready = rst && !flush && !jump_valid_q && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign imm_ext       = DATA_W'($signed(imm_field));
    // Register-form jumps are pc-relative and wrap modulo the pc width.
    assign jump_target_d = isimm ? displ : in_pc + displ;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q   <= 1'b0;
            out_opcode_q  <= NOP;
            out_dest_q    <= '0;
            out_src_a_q   <= '0;
            out_data_a_q  <= '0;
            out_data_b_q  <= '0;
            out_imm_q     <= '0;
            out_isimm_q   <= 1'b0;
            out_pc_q      <= '0;
            jump_valid_q  <= 1'b0;
            jump_target_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (accept && !is_jmp) begin
                out_valid_q  <= 1'b1;
                out_opcode_q <= opc;
                out_dest_q   <= rd;
                out_src_a_q  <= ra;
                out_data_a_q <= rf_data_a;
                out_data_b_q <= isimm ? '0 : rf_data_b;
                out_imm_q    <= isimm ? imm_ext : '0;
                out_isimm_q  <= isimm;
                out_pc_q     <= in_pc;
            end else if (out_ready) begin
                // Drain, or a JMP consumed as a bubble.
                out_valid_q <= 1'b0;
            end

            jump_valid_q <= accept && is_jmp;
            if (accept && is_jmp) jump_target_q <= jump_target_d;

            if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_opcode  = out_opcode_q;
    assign out_dest    = out_dest_q;
    assign out_src_a   = out_src_a_q;
    assign out_data_a  = out_data_a_q;
    assign out_data_b  = out_data_b_q;
    assign out_imm     = out_imm_q;
    assign out_isimm   = out_isimm_q;
    assign out_pc      = out_pc_q;
    assign jump_valid  = jump_valid_q;
    assign jump_target = jump_target_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cycle table, stall-counter saturation run,
// then randomized traffic against a rule-level reference model.
module tb_decode_stage;
    import pigro_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RA_W   = 4;
    localparam int unsigned PC_W   = 5;
    localparam int unsigned IMM_W  = 18;
    localparam int unsigned NSRC   = 3;

    logic                 clk = 1'b0;
    logic                 rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]          in_instr;
    logic [PC_W-1:0]      in_pc;
    logic [RA_W-1:0]      rf_addr_a, rf_addr_b, out_dest, out_src_a;
    logic [DATA_W-1:0]    rf_data_a, rf_data_b, out_data_a, out_data_b, out_imm;
    logic [NSRC*RA_W-1:0] hz_dst;
    logic [NSRC-1:0]      hz_wen;
    logic [4:0]           out_opcode;
    logic                 out_isimm, jump_valid, stall;
    logic [PC_W-1:0]      out_pc, jump_target;
    logic [15:0]          stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_stage #(
        .DATA_W (DATA_W), .RA_W (RA_W), .PC_W (PC_W), .IMM_W (IMM_W), .NSRC (NSRC)
    ) dut (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
        .in_instr (in_instr), .in_pc (in_pc), .rf_addr_a (rf_addr_a), .rf_addr_b (rf_addr_b),
        .rf_data_a (rf_data_a), .rf_data_b (rf_data_b), .hz_dst (hz_dst), .hz_wen (hz_wen),
        .flush (flush), .out_valid (out_valid), .out_ready (out_ready),
        .out_opcode (out_opcode), .out_dest (out_dest), .out_src_a (out_src_a),
        .out_data_a (out_data_a), .out_data_b (out_data_b), .out_imm (out_imm),
        .out_isimm (out_isimm), .out_pc (out_pc), .jump_valid (jump_valid),
        .jump_target (jump_target), .stall (stall), .stall_cnt (stall_cnt)
    );

    typedef struct {
        logic        rst, iv, ordy, fl;
        logic [31:0] instr;
        logic [4:0]  pc;
        logic [11:0] hzd;
        logic [2:0]  hzw;
        logic [31:0] da, db;
        logic        e_ir, e_st, e_ov, e_jv;
        logic [4:0]  e_jt;
        logic        e_chk;
        logic [31:0] e_da, e_db, e_imm;
        logic [15:0] e_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] opc, input logic imm,
                                       input logic [3:0] rd, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [13:0] low);
        return {opc, imm, rd, ra, rb, low};
    endfunction

    function automatic vec_t row(
        input logic r, input logic iv, input logic [31:0] ins, input logic [4:0] pc,
        input logic [11:0] hzd, input logic [2:0] hzw, input logic ordy, input logic fl,
        input logic [31:0] da, input logic [31:0] db,
        input logic ir, input logic st, input logic ov, input logic jv, input logic [4:0] jt,
        input logic c, input logic [31:0] eda, input logic [31:0] edb,
        input logic [31:0] eimm, input logic [15:0] cnt);
        vec_t v;
        v.rst = r; v.iv = iv; v.instr = ins; v.pc = pc; v.hzd = hzd; v.hzw = hzw;
        v.ordy = ordy; v.fl = fl; v.da = da; v.db = db;
        v.e_ir = ir; v.e_st = st; v.e_ov = ov; v.e_jv = jv; v.e_jt = jt; v.e_chk = c;
        v.e_da = eda; v.e_db = edb; v.e_imm = eimm; v.e_cnt = cnt;
        return v;
    endfunction

    // Spec-level hazard: the set of sources the opcode reads, against enabled slots.
    function automatic logic hazard_ref(input logic [31:0] ins, input logic [11:0] hzd,
                                        input logic [2:0] hzw);
        logic [3:0] srcs[$];
        if (ins[31:27] != NOP && ins[31:27] != JMP) begin
            srcs.push_back(ins[21:18]);
            if (!ins[26]) srcs.push_back(ins[17:14]);
        end
        for (int i = 0; i < 3; i++)
            if (hzw[i])
                foreach (srcs[j]) if (hzd[i*4 +: 4] == srcs[j]) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model state
    logic        m_ov, m_jv, m_isimm;
    logic [4:0]  m_op, m_jt, m_pc;
    logic [3:0]  m_dest, m_srca;
    logic [31:0] m_da, m_db, m_imm;
    int unsigned m_cnt;

    logic [31:0] ins_a, ins_i, ins_j, ins_j2;
    vec_t        tbl[$];

    initial begin
        ins_a  = mk(ADD, 1'b0, 4'd3, 4'd1, 4'd2, 14'd0);
        ins_i  = mk(ADD, 1'b1, 4'd4, 4'd1, 4'hF, 14'h3FFF);
        ins_j  = mk(JMP, 1'b0, 4'd0, 4'd0, 4'd0, 14'd5);
        ins_j2 = mk(JMP, 1'b1, 4'd0, 4'd0, 4'd0, 14'd7);

        // rst iv instr pc hzd hzw ordy fl da db | ir st ov jv jt chk da db imm cnt
        tbl.push_back(row(0, 1, ins_a, 0, 12'h000, 3'b000, 1, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, ins_a, 0, 12'h000, 3'b000, 1, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 1, ins_a, 0, 12'h020, 3'b010, 1, 0, 0, 0,
                          0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(row(1, 1, ins_a, 0, 12'h020, 3'b010, 1, 0, 0, 0,
                          0, 1, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(row(1, 1, ins_a, 7, 12'h020, 3'b000, 1, 0, 32'h1111, 32'h2222,
                          1, 0, 1, 0, 0, 1, 32'h1111, 32'h2222, 0, 2));
        tbl.push_back(row(1, 1, ins_i, 8, 12'h00F, 3'b001, 1, 0, 32'h33, 32'h44,
                          1, 0, 1, 0, 0, 1, 32'h33, 0, 32'hFFFFFFFF, 2));
        tbl.push_back(row(1, 1, ins_j, 30, 12'h000, 3'b000, 1, 0, 0, 0,
                          1, 0, 0, 1, 3, 0, 0, 0, 0, 2));
        tbl.push_back(row(1, 1, ins_a, 31, 12'h000, 3'b000, 1, 0, 32'h55, 0,
                          0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(row(1, 1, ins_a, 9, 12'h000, 3'b000, 0, 0, 32'h66, 32'h77,
                          1, 0, 1, 0, 0, 1, 32'h66, 32'h77, 0, 2));
        for (int k = 0; k < 3; k++)
            tbl.push_back(row(1, 1, ins_i, 10, 12'h000, 3'b000, 0, 0, 32'h99, 0,
                              0, 0, 1, 0, 0, 1, 32'h66, 32'h77, 0, 2));
        tbl.push_back(row(1, 1, ins_i, 10, 12'h000, 3'b000, 1, 0, 32'h99, 0,
                          1, 0, 1, 0, 0, 1, 32'h99, 0, 32'hFFFFFFFF, 2));
        tbl.push_back(row(1, 1, ins_a, 11, 12'h000, 3'b000, 0, 1, 32'hAA, 0,
                          0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(row(1, 0, ins_a, 0, 12'h000, 3'b000, 1, 0, 0, 0,
                          1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(row(1, 1, ins_j2, 20, 12'h000, 3'b000, 1, 0, 0, 0,
                          1, 0, 0, 1, 7, 0, 0, 0, 0, 2));
        tbl.push_back(row(1, 0, ins_a, 0, 12'h000, 3'b000, 1, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(row(1, 1, ins_a, 0, 12'h121, 3'b000, 0, 0, 32'h5, 32'h6,
                          1, 0, 1, 0, 0, 1, 32'h5, 32'h6, 0, 2));
        tbl.push_back(row(1, 1, ins_a, 0, 12'h100, 3'b100, 1, 0, 0, 0,
                          0, 1, 0, 0, 0, 0, 0, 0, 0, 3));

        #1;
        foreach (tbl[k]) begin
            rst = tbl[k].rst; in_valid = tbl[k].iv; in_instr = tbl[k].instr;
            in_pc = tbl[k].pc; hz_dst = tbl[k].hzd; hz_wen = tbl[k].hzw;
            out_ready = tbl[k].ordy; flush = tbl[k].fl;
            rf_data_a = tbl[k].da; rf_data_b = tbl[k].db;
            #3;
            chk($sformatf("row%0d in_ready", k), in_ready, tbl[k].e_ir);
            chk($sformatf("row%0d stall", k), stall, tbl[k].e_st);
            @(posedge clk); #1;
            chk($sformatf("row%0d out_valid", k), out_valid, tbl[k].e_ov);
            chk($sformatf("row%0d jump_valid", k), jump_valid, tbl[k].e_jv);
            chk($sformatf("row%0d stall_cnt", k), stall_cnt, tbl[k].e_cnt);
            if (tbl[k].e_jv) chk($sformatf("row%0d jump_target", k), jump_target, tbl[k].e_jt);
            if (tbl[k].e_chk) begin
                chk($sformatf("row%0d out_data_a", k), out_data_a, tbl[k].e_da);
                chk($sformatf("row%0d out_data_b", k), out_data_b, tbl[k].e_db);
                chk($sformatf("row%0d out_imm", k), out_imm, tbl[k].e_imm);
            end
            if (!tbl[k].rst) begin
                chk($sformatf("row%0d rst out_opcode", k), out_opcode, NOP);
                chk($sformatf("row%0d rst out_pc", k), out_pc, 0);
                chk($sformatf("row%0d rst out_data_a", k), out_data_a, 0);
                chk($sformatf("row%0d rst jump_target", k), jump_target, 0);
            end
        end

        // Hold the hazard from the last row until the counter saturates.
        repeat (65531) @(posedge clk);
        #1 chk("sat stall_cnt FFFE", stall_cnt, 16'hFFFE);
        @(posedge clk); #1 chk("sat stall_cnt FFFF", stall_cnt, 16'hFFFF);
        repeat (5) @(posedge clk);
        #1 chk("sat stall_cnt held", stall_cnt, 16'hFFFF);
        chk("sat stall", stall, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1 chk("flush keeps stall_cnt", stall_cnt, 16'hFFFF);
        chk("flush out_valid", out_valid, 1'b0);
        flush = 1'b0; rst = 1'b0;
        @(posedge clk); #1 chk("reset stall_cnt", stall_cnt, 16'h0);
        chk("reset out_valid", out_valid, 1'b0);
        rst = 1'b1;
        m_ov = 0; m_jv = 0; m_jt = 0; m_cnt = 0; m_op = NOP; m_pc = 0; m_dest = 0;
        m_srca = 0; m_da = 0; m_db = 0; m_imm = 0; m_isimm = 0;

        for (int c = 0; c < 3000; c++) begin
            logic [4:0] opc;
            logic       hz, rdy, acc;
            opc = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) opc = 5'($urandom_range(0, 31));
            in_instr = {opc, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 14'($urandom)};
            in_pc     = 5'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rf_data_a = $urandom;
            rf_data_b = $urandom;
            for (int i = 0; i < 3; i++) begin
                hz_dst[i*4 +: 4] = 4'($urandom_range(0, 3));
                hz_wen[i]        = ($urandom_range(0, 3) == 0);
            end
            hz  = hazard_ref(in_instr, hz_dst, hz_wen);
            rdy = !flush && !m_jv && !hz && (!m_ov || out_ready);
            acc = in_valid && rdy;
            #3;
            chk("rnd in_ready", in_ready, rdy);
            chk("rnd stall", stall, in_valid && hz);
            chk("rnd rf_addr_a", rf_addr_a, in_instr[21:18]);
            chk("rnd rf_addr_b", rf_addr_b, in_instr[17:14]);

            if (in_valid && hz && m_cnt < 65535) m_cnt++;
            m_jv = acc && (opc == JMP);
            if (m_jv) m_jt = in_instr[26] ? in_instr[4:0] : 5'((in_pc + in_instr[4:0]) % 32);
            if (flush) m_ov = 0;
            else if (acc && opc != JMP) begin
                m_ov = 1; m_op = opc; m_dest = in_instr[25:22]; m_srca = in_instr[21:18];
                m_isimm = in_instr[26]; m_pc = in_pc; m_da = rf_data_a;
                m_db  = in_instr[26] ? 32'd0 : rf_data_b;
                m_imm = in_instr[26] ? 32'($signed(in_instr[17:0])) : 32'd0;
            end else if (out_ready) m_ov = 0;

            @(posedge clk); #1;
            chk("rnd out_valid", out_valid, m_ov);
            chk("rnd jump_valid", jump_valid, m_jv);
            chk("rnd stall_cnt", stall_cnt, m_cnt);
            if (m_jv) chk("rnd jump_target", jump_target, m_jt);
            if (m_ov) begin
                chk("rnd out_opcode", out_opcode, m_op);
                chk("rnd out_dest", out_dest, m_dest);
                chk("rnd out_src_a", out_src_a, m_srca);
                chk("rnd out_data_a", out_data_a, m_da);
                chk("rnd out_data_b", out_data_b, m_db);
                chk("rnd out_imm", out_imm, m_imm);
                chk("rnd out_isimm", out_isimm, m_isimm);
                chk("rnd out_pc", out_pc, m_pc);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised decode/issue stage for the PIGRO pipeline, sitting between fetch and execute. It splits the 32-bit instruction, drives the register-file read addresses, and detects RAW hazards against a configurable number of downstream write ports, using explicit write-enable qualifiers. Jumps are resolved locally. Decoded operands are held in a valid/ready output register, with flush support and a saturating stall counter.

## Interface
- DATA_W, 32: operand/immediate width (≥ IMM_W)
- RA_W, 4: register address width (≤ 4; field slots in instruction are 4 bits, upper bits ignored)
- PC_W, 5: program-counter width
- IMM_W, 18: immediate field width, sign-extended to DATA_W
- NSRC, 3: number of downstream destination ports checked for hazards
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  decode accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  PC_W  pc of in_instr
- rf_addr_a, rf_addr_b  out  RA_W  regfile read addresses (combinational from in_instr)
- rf_data_a, rf_data_b  in  DATA_W  regfile read data, same cycle
- hz_dst  in  NSRC*RA_W  downstream destination addresses, slot i at [i*RA_W +: RA_W]
- hz_wen  in  NSRC  slot i will write hz_dst slot i
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  execute accepts
- out_opcode  out  5;  out_dest, out_src_a  out  RA_W;  out_data_a, out_data_b, out_imm  out  DATA_W;  out_isimm  out  1;  out_pc  out  PC_W
- jump_valid  out  1  one-cycle redirect pulse
- jump_target  out  PC_W  redirect pc
- stall  out  1  in_valid && hazard (combinational)
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Fields (package constants): opcode [31:27], imm flag [26], Rd [25:22], Ra [21:18], Rb [17:14], immediate [IMM_W-1:0], displacement [PC_W-1:0].
- Sources: Ra is used by every opcode except NOP and JMP. Rb is used only when imm=0 and opcode is not NOP/JMP.
- hazard = OR over i of (hz_wen[i] && hz_dst[i] == used source). Slots with hz_wen=0 never match; X is not used as a qualifier.
- in_ready = rst && !flush && !jump_valid && !hazard && (!out_valid || out_ready).
- Accept (in_valid && in_ready), non-JMP: the output register loads all fields and out_valid=1. out_data_b=0 and out_imm=sign-extended immediate when imm=1; otherwise out_imm=0.
- Accept, JMP: the output register is not loaded; it is consumed as a bubble. jump_valid=1 next cycle. jump_target = displ if imm=1, else (pc + displ) mod 2^PC_W.
- Output register drains when out_ready=1 and no new accept occurs; out_valid then goes to 0.
- Hazard with a free output slot: the instruction is held upstream and a bubble is issued (out_valid=0). stall_cnt increments each cycle stall=1 and saturates at 16'hFFFF.
- Flush: out_valid and jump_valid clear next cycle; stall_cnt is kept.

## Timing
- Decode latency: one cycle from accept to out_valid/jump_valid.
- Reset (rst=0 at clk): out_valid=0, jump_valid=0, out_opcode=NOP, all data/address/pc outputs 0, stall_cnt=0. rst beats flush.
- During the jump_valid cycle, in_ready=0, so the wrong-path instruction presented by fetch is dropped. Fetch redirects from jump_target.
- Backpressure: while out_valid && !out_ready, all out_* are held stable.
- Flush coincident with a valid input: flush wins and nothing is accepted.
- Hazard and JMP together is impossible, since JMP has no sources.
- A pending jump_valid never blocks a held out_valid from draining.

## Structure
- Shared package `pigro_pkg`: opcode constants (NOP, JMP, STR, …) and field bit positions.
- Sub-module `hazard_cmp` (parameters NSRC, RA_W): inputs are the two source addresses plus use-bits and hz_dst/hz_wen; output is hazard.
- Sign extension stays inline.

## Test plan
- Reset: hold rst=0 for 2 cycles with in_valid=1 → out_valid=0, jump_valid=0, stall_cnt=0, in_ready=0.
- ADD R3,R1,R2 with hz_dst slot1=2, hz_wen=3'b010 for 2 cycles → stall=1 for 2 cycles, out_valid=0, stall_cnt=2. Then issue with data_a/b as read in the accept cycle.
- Immediate instruction, imm field 18'h3FFFF, Rb slot matching hz_dst with wen=1 → no stall, out_imm=32'hFFFFFFFF, out_data_b=0.
- JMP register form at pc=30, displ=5 → jump_valid one cycle, jump_target=3, out_valid stays 0, next instruction dropped.
- out_ready=0 for 3 cycles after an issue → out_* stable, in_ready=0. out_ready=1 → next instruction issues on the following cycle.
- flush asserted with out_valid=1 and in_valid=1 → out_valid=0 next cycle, input not accepted. stall_cnt preset near 16'hFFFF stays saturated under continued stall.
